logic_gate_pipe: RTL and testbench
==================================

LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 1..64).
REQ-002 Parameter OP_W, default 3, opcode width in bits (fixed at 3).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set a/b/op is valid this cycle.
REQ-006 in_ready  output  1  block can accept an operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  OP_W  operation select.
REQ-010 out_valid  output  1  y is a valid result.
REQ-011 out_ready  input  1  consumer accepts y this cycle.
REQ-012 y  output  WIDTH  bitwise result, head of output queue.
REQ-013 err  output  1  sticky illegal-opcode flag.
REQ-014 y_red  output  1  reduction of y (present only with GATE_REDUCE_EN; see Configuration).

Function
REQ-015 Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, all bitwise a-op-b across WIDTH bits.
REQ-016 Opcodes 6 and 7 are illegal: the transaction is still accepted, its result is all-zero, and err is set at the accepting edge.
REQ-017 Once set, err holds at 1 until reset; it is not cleared by later legal ops.
REQ-018 Transaction accepted on a rising edge where in_valid=1 and in_ready=1; a, b and op are sampled only on that edge.
REQ-019 Results are held in a 2-entry FIFO; results leave in acceptance order.
REQ-020 in_ready = 1 when FIFO occupancy < 2. It is a registered function of occupancy only, with no combinational path from out_ready.
REQ-021 When full, in_ready = 0 even if out_ready = 1 in the same cycle; the freed slot becomes visible the following cycle.
REQ-022 out_valid = 1 whenever occupancy > 0; y shows the head entry; y is 0 when occupancy = 0.
REQ-023 Pop on a rising edge where out_valid=1 and out_ready=1.
REQ-024 Latency: a result accepted at edge N is visible on y with out_valid=1 after edge N, provided the FIFO was empty before N.
REQ-025 Simultaneous push and pop at occupancy 1: occupancy stays 1, y advances to the new result.
REQ-026 y and out_valid are stable while out_valid=1 and out_ready=0.
REQ-027 Read and write pointers wrap modulo 2; occupancy is a 2-bit counter in range 0..2.

Reset
REQ-028 While rst=1: occupancy=0, pointers=0, out_valid=0, y=0, err=0, y_red=0, and in_ready=0.
REQ-029 in_ready rises on the first clk edge after rst deasserts.
REQ-030 Reset mid-operation discards all queued results immediately (asynchronously); no partial result emerges afterwards.

Configuration
REQ-031 Macro GATE_REDUCE_EN: when defined, port y_red exists.
REQ-032 With GATE_REDUCE_EN, y_red is the reduction of the head entry's y using the reduction matching its stored op: AND/NAND give &y, OR/NOR give |y, XOR/XNOR give ^y, and an illegal op gives 0.
REQ-033 With GATE_REDUCE_EN, y_red is 0 when out_valid=0.
REQ-034 Without GATE_REDUCE_EN, port y_red and the stored-op field are absent, and all other behaviour is identical.

Verification (WIDTH=8)
REQ-035 Reset, then push a=F0 b=3C op=0 with out_ready=1 -> next cycle out_valid=1, y=30, err=0; with GATE_REDUCE_EN, y_red=0.
REQ-036 Sweep ops 1..5 with a=F0 b=3C -> y = FC, CC, CF, 03, 33 in order.
REQ-037 out_ready=0, push three sets -> in_ready drops after the 2nd accept, the 3rd is held; raise out_ready -> results emerge in order with no loss or duplication.
REQ-038 Push op=6 -> y=00, err=1; then push op=0 -> err remains 1.
REQ-039 Occupancy 1 with simultaneous push/pop -> out_valid stays 1 and y changes to the new result the next cycle.
REQ-040 Assert rst with 2 entries queued -> out_valid=0 and y=00 immediately; after release, no stale result appears.

Source files
------------

// File: rtl/logic_gate_pipe.sv
// Bitwise gate unit with a 2-entry result FIFO and registered input backpressure.
// Optional macro GATE_REDUCE_EN adds y_red, a per-entry reduction of the head result.
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err
`ifdef GATE_REDUCE_EN
  ,
  output logic             y_red
`endif
);

  logic [1:0][WIDTH-1:0] y_mem_q;
`ifdef GATE_REDUCE_EN
  logic [1:0][OP_W-1:0]  op_mem_q;
`endif
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  in_ready_q, err_q, err_d;
  logic                  push, pop, illegal;
  logic [WIDTH-1:0]      res_d;

  assign push    = in_valid && in_ready_q;
  assign pop     = (cnt_q != 2'd0) && out_ready;
  assign illegal = (op > OP_W'(5));

  always_comb begin
    res_d = '0;
    case (op)
      OP_W'(0): res_d = a & b;
      OP_W'(1): res_d = a | b;
      OP_W'(2): res_d = a ^ b;
      OP_W'(3): res_d = ~(a & b);
      OP_W'(4): res_d = ~(a | b);
      OP_W'(5): res_d = ~(a ^ b);
      default:  res_d = '0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (!push && pop) cnt_d = cnt_q - 2'd1;
    err_d = err_q | (push & illegal);
  end

  // in_ready is registered from the next occupancy, so a pop never frees a slot in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_mem_q    <= '0;
`ifdef GATE_REDUCE_EN
      op_mem_q   <= '0;
`endif
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        y_mem_q[wr_ptr_q]  <= res_d;
`ifdef GATE_REDUCE_EN
        op_mem_q[wr_ptr_q] <= op;
`endif
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d < 2'd2);
      err_q      <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (cnt_q != 2'd0);
  assign y         = out_valid ? y_mem_q[rd_ptr_q] : '0;
  assign err       = err_q;

`ifdef GATE_REDUCE_EN
  always_comb begin
    y_red = 1'b0;
    if (out_valid) begin
      case (op_mem_q[rd_ptr_q])
        OP_W'(0), OP_W'(3): y_red = &y;
        OP_W'(1), OP_W'(4): y_red = |y;
        OP_W'(2), OP_W'(5): y_red = ^y;
        default:            y_red = 1'b0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomized bench for logic_gate_pipe against a queue-based reference model.
module tb_logic_gate_pipe;
  localparam int W = 8;

  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   op = '0;
  logic         in_ready, out_valid, err;
  logic [W-1:0] y;
`ifdef GATE_REDUCE_EN
  logic         y_red;
`endif

  int checks = 0, errors = 0;

  logic [W-1:0] qy[$];
  logic [2:0]   qop[$];
  logic         m_err = 1'b0, m_ready = 1'b0;

  logic [7:0] sweep_exp [6] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33};

  logic_gate_pipe #(.WIDTH(W), .OP_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .err(err)
`ifdef GATE_REDUCE_EN
    , .y_red(y_red)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] gate_ref(input logic [W-1:0] x, input logic [W-1:0] z,
                                            input logic [2:0] o);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return x ^ z;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return ~(x ^ z);
      default: return '0;
    endcase
  endfunction

  function automatic logic red_ref(input logic [W-1:0] v, input logic [2:0] o);
    int n;
    n = $countones(v);
    case (o)
      3'd0, 3'd3: return n == W;
      3'd1, 3'd4: return n > 0;
      3'd2, 3'd5: return (n % 2) == 1;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    logic ev;
    ev = qy.size() > 0;
    chk({tag, ".valid"}, out_valid, ev);
    chk({tag, ".y"}, y, ev ? qy[0] : '0);
    chk({tag, ".ready"}, in_ready, m_ready);
    chk({tag, ".err"}, err, m_err);
`ifdef GATE_REDUCE_EN
    chk({tag, ".yred"}, y_red, ev ? red_ref(qy[0], qop[0]) : 1'b0);
`endif
  endtask

  // Advance one clock; model the edge from the inputs held stable across it.
  task automatic cycle();
    logic acc, pp;
    @(posedge clk);
    if (rst) begin
      qy.delete(); qop.delete();
      m_err = 1'b0; m_ready = 1'b0;
    end else begin
      acc = in_valid && m_ready;
      pp  = (qy.size() > 0) && out_ready;
      if (pp) begin
        void'(qy.pop_front()); void'(qop.pop_front());
      end
      if (acc) begin
        qy.push_back(gate_ref(a, b, op));
        qop.push_back(op);
        if (op > 3'd5) m_err = 1'b1;
      end
      m_ready = qy.size() < 2;
    end
    #1;
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    qy.delete(); qop.delete();
    m_err = 1'b0; m_ready = 1'b0;
    check_outputs(tag);
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #2;
    check_outputs("rst");
    cycle(); cycle();
    check_outputs("rst_hold");
    rst = 1'b0;
    cycle();
    check_outputs("rst_rel");

    // First result, then a back-to-back sweep through push+pop at occupancy 1.
    out_ready = 1'b1; in_valid = 1'b1; a = 8'hF0; b = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      op = 3'(i);
      cycle();
      check_outputs("sweep");
      chk("sweep_y", y, sweep_exp[i]);
      chk("sweep_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    cycle(); check_outputs("drain0");

    // Backpressure: stall the consumer and overfill.
    out_ready = 1'b0; in_valid = 1'b1;
    a = 8'h12; b = 8'h34; op = 3'd2; cycle(); check_outputs("bp1");
    a = 8'hA5; b = 8'h0F; op = 3'd0; cycle(); check_outputs("bp2");
    chk("bp_full_ready", in_ready, 1'b0);
    a = 8'h77; b = 8'h81; op = 3'd4; cycle(); check_outputs("bp3_held");
    out_ready = 1'b1;
    cycle(); check_outputs("bp_pop");
    chk("bp_free_ready", in_ready, 1'b1);
    cycle(); check_outputs("bp_acc3");
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin cycle(); check_outputs("bp_drain"); end

    // Illegal opcode and sticky error.
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'd6;
    cycle(); check_outputs("ill");
    chk("ill_y", y, 8'h00);
    chk("ill_err", err, 1'b1);
    op = 3'd0;
    cycle(); check_outputs("ill_next");
    chk("err_sticky", err, 1'b1);
    in_valid = 1'b0;
    cycle(); check_outputs("ill_drain");

    // Reset with two entries queued.
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h5A; b = 8'hC3; op = 3'd1;
    cycle(); cycle();
    in_valid = 1'b0;
    check_outputs("pre_rst");
    async_reset("mid_rst");
    chk("mid_rst_y", y, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin cycle(); check_outputs("post_rst"); end

    for (int n = 0; n < 600; n++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      op        = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
      cycle();
      check_outputs("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
